rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Drives the single write port (we3/wa3/wd3) of the CPU register file.
- Merges two writeback sources:
  - the in-order pipeline writeback, which is never stalled;
  - the out-of-order load-return channel from the data cache, which uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a pending-destination scoreboard so the hazard unit can stall readers of registers whose load data has not yet been written.

Parameters:
- DEPTH, 4, load-return FIFO entries (power of 2, ≥2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline writeback enable
- pipe_wa  in  AW  pipeline destination register
- pipe_wd  in  DW  pipeline write data
- ld_valid  in  1  load-return data valid
- ld_ready  out  1  arbiter can accept load return
- ld_wa  in  AW  load destination register
- ld_wd  in  DW  load data
- issue_valid  in  1  long-latency load issued this cycle
- issue_wa  in  AW  destination of the issued load
- ra1, ra2  in  AW  decode-stage source registers
- pend_hit1, pend_hit2  out  1  source register has a write pending (combinational)
- we3  out  1  register-file write enable (registered)
- wa3  out  AW  register-file write address (registered)
- wd3  out  DW  register-file write data (registered)
- fifo_count  out  log2(DEPTH)+1  FIFO occupancy
- busy  out  1  FIFO non-empty or any pending bit set

Behaviour:
- Reset:
  - we3=0, wa3=0, wd3=0.
  - FIFO emptied; pointers and fifo_count cleared.
  - Pending bitmap cleared; busy=0.
  - ld_ready=0 while rst is high.
  - Reset mid-operation discards buffered load returns with no write.
- Handshake:
  - ld_ready = !rst && (fifo_count != DEPTH), evaluated from the start-of-cycle count.
  - A push occurs when ld_valid && ld_ready.
  - When full, no push is accepted even if a pop happens in the same cycle.
  - ld_valid may stay high while ld_ready is low; the data must remain stable until accepted.
- Arbitration (one write per cycle, output registered, 1-cycle latency):
  - Priority 1: pipe_we && pipe_wa!=0 → we3=1, wa3=pipe_wa, wd3=pipe_wd. The FIFO does not pop.
  - Priority 2: else if the FIFO is non-empty → pop head; we3 = (head.wa != 0); wa3/wd3 = head.
  - Otherwise we3=0; wa3/wd3 hold their previous values.
  - A pipe write to r0 is dropped and does not block the FIFO pop.
- FIFO:
  - Circular buffer with wrap-around pointers and an AW+DW entry.
  - Push and pop in the same cycle leave the count unchanged.
  - Load returns are written in acceptance order.
- Scoreboard (bitmap of 2^AW bits, bit 0 hardwired to 0):
  - Set bit issue_wa on issue_valid.
  - Clear bit head.wa on the cycle its FIFO entry pops.
  - Simultaneous set and clear on the same address: set wins.
  - Pipeline writes never modify the bitmap.
  - pend_hitN = bitmap[raN], combinational.
- WAW ordering: the hazard unit must stall any instruction whose destination has its pending bit set. The arbiter does not reorder.
- busy = (fifo_count != 0) || (|bitmap).
- Starvation: sustained pipe writes to non-zero registers starve the FIFO. This is permitted, because the pending stall eventually drains the pipeline.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- When defined:
  - Adds outputs fwd_hit1, fwd_hit2 (1 bit) and fwd_data1, fwd_data2 (DW).
  - fwd_hitN = we3 && (wa3 == raN) && (raN != 0); fwd_dataN = wd3.
  - This covers the cycle before the register file commits the write. The decoder muxes fwd_dataN over rdN.
- When undefined: these ports are absent and there is no forwarding logic.

Test Plan:
- Reset: assert rst for 2 cycles while ld_valid=1 → we3=0, ld_ready=0, fifo_count=0, busy=0. After release, ld_ready=1.
- Pipe-only write: pipe_we=1, pipe_wa=5, pipe_wd=0x1234 → next cycle we3=1, wa3=5, wd3=0x1234. With pipe_wa=0 → we3=0.
- Load path with scoreboard:
  - issue_valid with issue_wa=8 → pend_hit1=1 for ra1=8.
  - Then push ld_wa=8, ld_wd=0xDEAD → next cycle we3=1, wa3=8, wd3=0xDEAD, and pend_hit1 returns to 0 in the same cycle.
- Contention:
  - FIFO holds {wa=3, 0xA}.
  - pipe_we on r4 for 3 cycles → 3 pipe writes; FIFO count stays 1.
  - On the 4th cycle the r3 write is emitted.
- Full/wrap:
  - With pipe_we held high, push 4 entries → fifo_count=4, ld_ready=0, and a 5th ld_valid is not accepted.
  - Release pipe_we → entries drain in order over 4 cycles; pointers wrap on a subsequent push of 2 more entries, which are written in order.
- Set/clear collision: head pops wa=9 in the same cycle as issue_valid with issue_wa=9 → bit 9 remains set and pend_hit=1 for ra=9.

Source files
------------

// File: rtl/rf_wb_if.sv
// rf_wb_if: writeback sources, load-return handshake, hazard lookups and register-file write port
interface rf_wb_if #(parameter int AW = 5, parameter int DW = 32, parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          pipe_we;
  logic [AW-1:0] pipe_wa;
  logic [DW-1:0] pipe_wd;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_wa;
  logic [DW-1:0] ld_wd;
  logic          issue_valid;
  logic [AW-1:0] issue_wa;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic          pend_hit1;
  logic          pend_hit2;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [CW-1:0] fifo_count;
  logic          busy;
`ifdef RF_WB_BYPASS_EN
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data1;
  logic [DW-1:0] fwd_data2;
`endif
  modport master (
    output pipe_we, pipe_wa, pipe_wd, ld_valid, ld_wa, ld_wd, issue_valid, issue_wa, ra1, ra2,
`ifdef RF_WB_BYPASS_EN
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    input  ld_ready, pend_hit1, pend_hit2, we3, wa3, wd3, fifo_count, busy
  );
  modport slave (
    input  pipe_we, pipe_wa, pipe_wd, ld_valid, ld_wa, ld_wd, issue_valid, issue_wa, ra1, ra2,
`ifdef RF_WB_BYPASS_EN
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    output ld_ready, pend_hit1, pend_hit2, we3, wa3, wd3, fifo_count, busy
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges pipeline writeback and buffered load returns onto one RF write port; RF_WB_BYPASS_EN adds write-stage forwarding
module rf_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic   clk,
  input logic   rst,
  rf_wb_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    rp, wp;
  logic [CW-1:0]    count;
  logic [2**AW-1:0] pend, pend_n;
  logic             push, pop, pipe_wr;
  logic [AW-1:0]    head_wa;
  logic [DW-1:0]    head_wd;
  assign {head_wa, head_wd} = mem[rp];
  assign bus.ld_ready   = !rst && (count != CW'(DEPTH));
  assign push           = bus.ld_valid && bus.ld_ready;
  assign pipe_wr        = bus.pipe_we && (bus.pipe_wa != '0);
  assign pop            = !pipe_wr && (count != '0);
  assign bus.fifo_count = count;
  assign bus.pend_hit1  = pend[bus.ra1];
  assign bus.pend_hit2  = pend[bus.ra2];
  assign bus.busy       = (count != '0) || (|pend);
  // load-return storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk)
    if (push) mem[wp] <= {bus.ld_wa, bus.ld_wd};
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // scoreboard next value: pop clears, issue sets afterwards so set wins; r0 never pending
  always_comb begin
    pend_n = pend;
    if (pop) pend_n[head_wa] = 1'b0;
    if (bus.issue_valid) pend_n[bus.issue_wa] = 1'b1;
    pend_n[0] = 1'b0;
  end
  // scoreboard register
  always_ff @(posedge clk)
    pend <= rst ? '0 : pend_n;
  // registered write port: pipeline first, otherwise FIFO head; address/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.we3 <= 1'b0;
      bus.wa3 <= '0;
      bus.wd3 <= '0;
    end else if (pipe_wr) begin
      bus.we3 <= 1'b1;
      bus.wa3 <= bus.pipe_wa;
      bus.wd3 <= bus.pipe_wd;
    end else if (pop) begin
      bus.we3 <= head_wa != '0;
      bus.wa3 <= head_wa;
      bus.wd3 <= head_wd;
    end else begin
      bus.we3 <= 1'b0;
    end
  end
`ifdef RF_WB_BYPASS_EN
  assign bus.fwd_hit1  = bus.we3 && (bus.wa3 == bus.ra1) && (bus.ra1 != '0);
  assign bus.fwd_hit2  = bus.we3 && (bus.wa3 == bus.ra2) && (bus.ra2 != '0);
  assign bus.fwd_data1 = bus.wd3;
  assign bus.fwd_data2 = bus.wd3;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed table, corner sequences and random traffic against a queue-based model
module tb_rf_write_arbiter;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  rf_wb_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();
  rf_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {logic [AW-1:0] wa; logic [DW-1:0] wd;} ent_t;
  typedef struct {
    logic pwe; logic [AW-1:0] pwa; logic [DW-1:0] pwd;
    logic lv; logic [AW-1:0] lwa; logic [DW-1:0] lwd;
    logic iv; logic [AW-1:0] iwa; logic [AW-1:0] ra;
    logic we; logic [AW-1:0] wa; logic [DW-1:0] wd; logic [2:0] cnt; logic ph; logic bz;
  } vec_t;
  ent_t q[$];
  logic [2**AW-1:0] pend;
  logic m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle();
    bus.pipe_we = 0; bus.pipe_wa = 0; bus.pipe_wd = 0;
    bus.ld_valid = 0; bus.ld_wa = 0; bus.ld_wd = 0;
    bus.issue_valid = 0; bus.issue_wa = 0; bus.ra1 = 0; bus.ra2 = 0;
  endtask
  task automatic tick();
    bit rdy;
    ent_t h;
    rdy = !rst && q.size() != DEPTH;
    if (rst) begin
      q.delete(); pend = '0; m_we = 0; m_wa = '0; m_wd = '0;
    end else begin
      if (bus.pipe_we && bus.pipe_wa != 0) begin
        m_we = 1; m_wa = bus.pipe_wa; m_wd = bus.pipe_wd;
      end else if (q.size() != 0) begin
        h = q.pop_front();
        m_we = h.wa != 0; m_wa = h.wa; m_wd = h.wd;
        pend[h.wa] = 1'b0;
      end else m_we = 0;
      if (bus.issue_valid) pend[bus.issue_wa] = 1'b1;
      pend[0] = 1'b0;
      if (bus.ld_valid && rdy) q.push_back({bus.ld_wa, bus.ld_wd});
    end
    @(posedge clk);
    #1;
    chk("we3", bus.we3, m_we);
    chk("wa3", bus.wa3, m_wa);
    chk("wd3", bus.wd3, m_wd);
    chk("fifo_count", bus.fifo_count, q.size());
    chk("ld_ready", bus.ld_ready, !rst && q.size() != DEPTH);
    chk("pend_hit1", bus.pend_hit1, pend[bus.ra1]);
    chk("pend_hit2", bus.pend_hit2, pend[bus.ra2]);
    chk("busy", bus.busy, q.size() != 0 || pend != 0);
  endtask
  task automatic do_reset();
    idle();
    rst = 1; bus.ld_valid = 1; bus.ld_wa = 5'd7; bus.ld_wd = 32'h77;
    tick();
    tick();
    chk("rst_we3", bus.we3, 0);
    chk("rst_ready", bus.ld_ready, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 0; bus.ld_valid = 0;
    #1;
    chk("post_rst_ready", bus.ld_ready, 1);
  endtask
  vec_t tbl[17];
  initial begin
    tbl[0]  = '{1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 0};
    tbl[1]  = '{1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0, 5, 32'h1234, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 8, 8, 0, 5, 32'h1234, 0, 1, 1};
    tbl[3]  = '{0, 0, 0, 1, 8, 32'hDEAD, 0, 0, 8, 0, 5, 32'h1234, 1, 1, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8, 1, 8, 32'hDEAD, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 3, 32'hA, 0, 0, 0, 0, 8, 32'hDEAD, 1, 0, 1};
    tbl[6]  = '{1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1, 1, 0, 1};
    tbl[7]  = '{1, 4, 2, 0, 0, 0, 0, 0, 0, 1, 4, 2, 1, 0, 1};
    tbl[8]  = '{1, 4, 3, 0, 0, 0, 0, 0, 0, 1, 4, 3, 1, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'hA, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'hA, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 3, 32'hA, 0, 1, 1};
    tbl[12] = '{0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0, 3, 32'hA, 1, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 9, 9, 1, 9, 32'h99, 0, 1, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 9, 32'h99, 0, 1, 1};
    tbl[15] = '{0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 9, 32'h99, 1, 0, 1};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1};
    rst = 1;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.pipe_we = tbl[i].pwe; bus.pipe_wa = tbl[i].pwa; bus.pipe_wd = tbl[i].pwd;
      bus.ld_valid = tbl[i].lv; bus.ld_wa = tbl[i].lwa; bus.ld_wd = tbl[i].lwd;
      bus.issue_valid = tbl[i].iv; bus.issue_wa = tbl[i].iwa; bus.ra1 = tbl[i].ra;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we3", i), bus.we3, tbl[i].we);
      chk($sformatf("v%0d_wa3", i), bus.wa3, tbl[i].wa);
      chk($sformatf("v%0d_wd3", i), bus.wd3, tbl[i].wd);
      chk($sformatf("v%0d_cnt", i), bus.fifo_count, tbl[i].cnt);
      chk($sformatf("v%0d_ph1", i), bus.pend_hit1, tbl[i].ph);
      chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].bz);
    end
    do_reset();
    bus.pipe_we = 1; bus.pipe_wa = 5'd1;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1; bus.ld_wa = AW'(10 + i); bus.ld_wd = 32'h100 + i; bus.pipe_wd = i;
      tick();
    end
    chk("full_count", bus.fifo_count, 4);
    chk("full_ready", bus.ld_ready, 0);
    bus.ld_wa = 5'd14; bus.ld_wd = 32'h104;
    tick();
    chk("full_reject", bus.fifo_count, 4);
    bus.pipe_we = 0; bus.ld_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_wa", bus.wa3, 10 + i);
    end
    bus.pipe_we = 1;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1; bus.ld_wa = AW'(20 + i); bus.ld_wd = 32'h200 + i;
      tick();
    end
    bus.pipe_we = 0; bus.ld_valid = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wrap_wd", bus.wd3, 32'h200 + i);
    end
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 199) == 0;
      bus.pipe_we = $urandom_range(0, 1);
      bus.pipe_wa = AW'($urandom_range(0, 7));
      bus.pipe_wd = $urandom;
      if (!(bus.ld_valid && !bus.ld_ready)) begin
        bus.ld_valid = $urandom_range(0, 1);
        bus.ld_wa = AW'($urandom_range(0, 7));
        bus.ld_wd = $urandom;
      end
      bus.issue_valid = $urandom_range(0, 3) == 0;
      bus.issue_wa = AW'($urandom_range(0, 7));
      bus.ra1 = AW'($urandom_range(0, 7));
      bus.ra2 = AW'($urandom_range(0, 7));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
